// File: rtl/wb_pkg.sv
// Shared defaults for the writeback arbiter slice: register address/data
// widths and the record describing one register-file write request.
package wb_pkg;

    localparam int WB_ADDR_SIZE = 5;
    localparam int WB_WORD_SIZE = 32;

    typedef struct packed {
        logic                    we;
        logic [WB_ADDR_SIZE-1:0] addr;
        logic [WB_WORD_SIZE-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/wb_pend_fifo.sv
// Pending-write FIFO for long-latency results, with two address-match
// ports so decode can see which destinations are still in flight.
module wb_pend_fifo #(
    parameter int ADDR_SIZE = 5,
    parameter int WORD_SIZE = 32,
    parameter int DEPTH     = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic [ADDR_SIZE-1:0] push_addr,
    input  logic [WORD_SIZE-1:0] push_data,
    input  logic                 pop,
    output logic                 full,
    output logic                 empty,
    output logic [ADDR_SIZE-1:0] head_addr,
    output logic [WORD_SIZE-1:0] head_data,
    input  logic [ADDR_SIZE-1:0] match_addr_a,
    input  logic [ADDR_SIZE-1:0] match_addr_b,
    output logic                 match_a,
    output logic                 match_b
);

    localparam int PW = $clog2(DEPTH);

    logic [ADDR_SIZE-1:0] addr_mem [DEPTH];
    logic [WORD_SIZE-1:0] data_mem [DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [PW:0]          count;
    logic                 do_push;
    logic                 do_pop;

    assign full      = (count == (PW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push & ~full;
    assign do_pop    = pop & ~empty;
    assign head_addr = addr_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            addr_mem[wr_ptr] <= push_addr;
            data_mem[wr_ptr] <= push_data;
        end
    end

    always_comb begin
        logic [PW-1:0] offset;
        match_a = 1'b0;
        match_b = 1'b0;
        offset  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset = PW'(i) - rd_ptr;
            if ((PW+1)'(offset) < count) begin
                if (match_addr_a != '0 && addr_mem[i] == match_addr_a) match_a = 1'b1;
                if (match_addr_b != '0 && addr_mem[i] == match_addr_b) match_b = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, long-latency
// results queue in wb_pend_fifo. Optional same-cycle bypass: WB_ARB_BYPASS_EN.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int ADDR_SIZE    = WB_ADDR_SIZE,
    parameter int WORD_SIZE    = WB_WORD_SIZE,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pipe_we,
    input  logic [ADDR_SIZE-1:0] pipe_addr,
    input  logic [WORD_SIZE-1:0] pipe_data,
    input  logic                 ll_valid,
    output logic                 ll_ready,
    input  logic [ADDR_SIZE-1:0] ll_addr,
    input  logic [WORD_SIZE-1:0] ll_data,
    input  logic [ADDR_SIZE-1:0] query_addr_a,
    input  logic [ADDR_SIZE-1:0] query_addr_b,
    output logic                 pend_a,
    output logic                 pend_b,
    output logic                 stall_req,
    output logic                 proto_err,
    output logic                 reg_d_we,
    output logic [ADDR_SIZE-1:0] reg_d_addr,
    output logic [WORD_SIZE-1:0] reg_d_data
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic                 full;
    logic                 empty;
    logic [ADDR_SIZE-1:0] head_addr;
    logic [WORD_SIZE-1:0] head_data;
    logic                 ll_fire;
    logic                 bypass;
    logic                 push;
    logic                 pop;
    logic [CW-1:0]        starve_cnt;
    logic [CW-1:0]        starve_cnt_nxt;
    wr_req_t              sel;

    assign ll_ready = rst_n & ~full;
    assign ll_fire  = ll_valid & ll_ready & (ll_addr != '0);
`ifdef WB_ARB_BYPASS_EN
    assign bypass   = ll_fire & ~pipe_we & empty;
`else
    assign bypass   = 1'b0;
`endif
    assign push     = ll_fire & ~bypass;
    assign pop      = rst_n & ~pipe_we & ~empty;

    wb_pend_fifo #(
        .ADDR_SIZE(ADDR_SIZE),
        .WORD_SIZE(WORD_SIZE),
        .DEPTH    (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push),
        .push_addr   (ll_addr),
        .push_data   (ll_data),
        .pop         (pop),
        .full        (full),
        .empty       (empty),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .match_addr_a(query_addr_a),
        .match_addr_b(query_addr_b),
        .match_a     (pend_a),
        .match_b     (pend_b)
    );

    always_comb begin
        sel = '0;
        if (!rst_n) begin
            sel = '0;
        end else if (pipe_we) begin
            sel.we   = 1'b1;
            sel.addr = WB_ADDR_SIZE'(pipe_addr);
            sel.data = WB_WORD_SIZE'(pipe_data);
        end else if (!empty) begin
            sel.we   = 1'b1;
            sel.addr = WB_ADDR_SIZE'(head_addr);
            sel.data = WB_WORD_SIZE'(head_data);
        end else if (bypass) begin
            sel.we   = 1'b1;
            sel.addr = WB_ADDR_SIZE'(ll_addr);
            sel.data = WB_WORD_SIZE'(ll_data);
        end
    end

    assign reg_d_we   = sel.we;
    assign reg_d_addr = ADDR_SIZE'(sel.addr);
    assign reg_d_data = WORD_SIZE'(sel.data);

    // A pop always relieves pressure; otherwise count full cycles up to the limit.
    always_comb begin
        starve_cnt_nxt = starve_cnt;
        if (pop)
            starve_cnt_nxt = '0;
        else if (full && starve_cnt != CW'(STARVE_LIMIT))
            starve_cnt_nxt = starve_cnt + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            stall_req  <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            starve_cnt <= starve_cnt_nxt;
            stall_req  <= (starve_cnt_nxt == CW'(STARVE_LIMIT));
            proto_err  <= proto_err | (pipe_we & stall_req);
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a queue-based model predicts every cycle's
// outputs; a negedge monitor pops and compares them against the DUT.
module tb_wb_arbiter;

    localparam int AW    = 5;
    localparam int WW    = 32;
    localparam int DEPTH = 2;
    localparam int LIMIT = 4;
`ifdef WB_ARB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pipe_we = 1'b0;
    logic [AW-1:0] pipe_addr = '0;
    logic [WW-1:0] pipe_data = '0;
    logic          ll_valid = 1'b0;
    logic          ll_ready;
    logic [AW-1:0] ll_addr = '0;
    logic [WW-1:0] ll_data = '0;
    logic [AW-1:0] query_addr_a = '0;
    logic [AW-1:0] query_addr_b = '0;
    logic          pend_a, pend_b, stall_req, proto_err, reg_d_we;
    logic [AW-1:0] reg_d_addr;
    logic [WW-1:0] reg_d_data;

    wb_arbiter #(
        .ADDR_SIZE(AW), .WORD_SIZE(WW), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_data(pipe_data),
        .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_addr(ll_addr), .ll_data(ll_data),
        .query_addr_a(query_addr_a), .query_addr_b(query_addr_b),
        .pend_a(pend_a), .pend_b(pend_b), .stall_req(stall_req), .proto_err(proto_err),
        .reg_d_we(reg_d_we), .reg_d_addr(reg_d_addr), .reg_d_data(reg_d_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [WW-1:0] data;
        logic          rdy;
        logic          pa;
        logic          pb;
        logic          stall;
        logic          perr;
    } exp_t;

    typedef struct {
        logic [AW-1:0] a;
        logic [WW-1:0] d;
    } ent_t;

    exp_t eq[$];
    ent_t mq[$];
    int   run = 0;
    bit   m_stall = 1'b0;
    bit   m_perr = 1'b0;
    int   n_total = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Advance the model across one clock edge using the inputs that were held.
    task automatic model_edge();
        bit full, fire, byp, popped, old_stall;
        if (!rst_n) begin
            mq.delete();
            run = 0;
            m_stall = 1'b0;
            m_perr = 1'b0;
        end else begin
            full      = (mq.size() == DEPTH);
            fire      = ll_valid && !full && (ll_addr != 0);
            byp       = BYP && fire && !pipe_we && (mq.size() == 0);
            popped    = !pipe_we && (mq.size() > 0);
            old_stall = m_stall;
            if (popped) void'(mq.pop_front());
            if (fire && !byp) mq.push_back('{a: ll_addr, d: ll_data});
            if (popped) run = 0;
            else if (full && run < LIMIT) run++;
            m_stall = (run >= LIMIT);
            m_perr  = m_perr || (pipe_we && old_stall);
        end
    endtask

    function automatic exp_t predict();
        exp_t e;
        bit   fire;
        e = '{we: 0, addr: '0, data: '0, rdy: 0, pa: 0, pb: 0, stall: 0, perr: 0};
        if (!rst_n) return e;
        e.rdy   = (mq.size() < DEPTH);
        e.stall = m_stall;
        e.perr  = m_perr;
        fire    = ll_valid && e.rdy && (ll_addr != 0);
        foreach (mq[i]) begin
            if (query_addr_a != 0 && mq[i].a == query_addr_a) e.pa = 1'b1;
            if (query_addr_b != 0 && mq[i].a == query_addr_b) e.pb = 1'b1;
        end
        if (pipe_we) begin
            e.we = 1'b1; e.addr = pipe_addr; e.data = pipe_data;
        end else if (mq.size() > 0) begin
            e.we = 1'b1; e.addr = mq[0].a; e.data = mq[0].d;
        end else if (BYP && fire) begin
            e.we = 1'b1; e.addr = ll_addr; e.data = ll_data;
        end
        return e;
    endfunction

    task automatic cyc(input bit rst, input bit we, input int wa, input logic [WW-1:0] wd,
                       input bit lv, input int la, input logic [WW-1:0] ld,
                       input int qa, input int qb);
        @(posedge clk);
        model_edge();
        #1;
        rst_n        = rst;
        pipe_we      = we;
        pipe_addr    = AW'(wa);
        pipe_data    = wd;
        ll_valid     = lv;
        ll_addr      = AW'(la);
        ll_data      = ld;
        query_addr_a = AW'(qa);
        query_addr_b = AW'(qb);
        eq.push_back(predict());
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (eq.size() > 0) begin
            e = eq.pop_front();
            chk("reg_d_we", WW'(reg_d_we), WW'(e.we));
            if (e.we) begin
                chk("reg_d_addr", WW'(reg_d_addr), WW'(e.addr));
                chk("reg_d_data", reg_d_data, e.data);
            end
            chk("ll_ready", WW'(ll_ready), WW'(e.rdy));
            chk("pend_a", WW'(pend_a), WW'(e.pa));
            chk("pend_b", WW'(pend_b), WW'(e.pb));
            chk("stall_req", WW'(stall_req), WW'(e.stall));
            chk("proto_err", WW'(proto_err), WW'(e.perr));
        end
    end

    initial begin
        int pw_pct;
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 4, 32'h1, 1, 5, 32'h2, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        // pipe write plus ll result to r7, then r7 drains
        cyc(1, 1, 3, 32'hA5A5A5A5, 1, 7, 32'h1234, 7, 3);
        cyc(1, 0, 0, 0, 0, 0, 0, 7, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 7, 0);
        // fill under continuous pipe writes, starve, then drain
        cyc(1, 1, 1, 32'h100, 1, 5, 32'h11, 5, 6);
        cyc(1, 1, 2, 32'h200, 1, 6, 32'h22, 5, 6);
        for (int i = 0; i < 7; i++) cyc(1, 1, 10 + i, 32'h300 + i, 1, 8, 32'h88, 5, 6);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0, 0, 0, 5, 6);
        // discarded r0 result, then single ll result on an empty buffer
        cyc(1, 0, 0, 0, 1, 0, 32'hDEAD, 0, 0);
        cyc(1, 0, 0, 0, 1, 9, 32'h55, 9, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 9, 0);
        // reset mid-operation drops buffered entries
        cyc(1, 1, 2, 32'h7, 1, 12, 32'hC, 12, 13);
        cyc(1, 1, 2, 32'h8, 1, 13, 32'hD, 12, 13);
        cyc(0, 0, 0, 0, 0, 0, 0, 12, 13);
        cyc(1, 0, 0, 0, 0, 0, 0, 12, 13);
        cyc(1, 0, 0, 0, 0, 0, 0, 12, 13);
        for (int ph = 0; ph < 3; ph++) begin
            pw_pct = (ph == 0) ? 90 : (ph == 1) ? 50 : 15;
            for (int i = 0; i < 200; i++) begin
                cyc(($urandom_range(99, 0) < 1) ? 1'b0 : 1'b1,
                    ($urandom_range(99, 0) < pw_pct),
                    int'($urandom_range(31, 0)), $urandom,
                    $urandom_range(1, 0) == 1, int'($urandom_range(7, 0)), $urandom,
                    int'($urandom_range(7, 0)), int'($urandom_range(7, 0)));
            end
        end
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        chk("scoreboard_drained", WW'(eq.size()), WW'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
  ADDR_SIZE, 5, register address width
  WORD_SIZE, 32, register data width
  DEPTH, 2, long-latency pending buffer entries (power of two, >=2)
  STARVE_LIMIT, 4, cycles a full buffer waits before stall_req
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 The ports SHALL be, one per line:
  clk  in  1  rising-edge clock
  rst_n  in  1  asynchronous active-low reset
  pipe_we  in  1  pipeline writeback write enable
  pipe_addr  in  ADDR_SIZE  pipeline destination register
  pipe_data  in  WORD_SIZE  pipeline write data
  ll_valid  in  1  long-latency unit (mult/div, uncached load) result valid
  ll_ready  out  1  arbiter accepts long-latency result
  ll_addr  in  ADDR_SIZE  long-latency destination register
  ll_data  in  WORD_SIZE  long-latency result
  query_addr_a  in  ADDR_SIZE  decode source register A
  query_addr_b  in  ADDR_SIZE  decode source register B
  pend_a  out  1  query A matches a buffered destination
  pend_b  out  1  query B matches a buffered destination
  stall_req  out  1  request to hold the pipeline writeback slot empty
  proto_err  out  1  sticky: pipe_we seen while stall_req high
  reg_d_we  out  1  register file write enable
  reg_d_addr  out  ADDR_SIZE  register file write address
  reg_d_data  out  WORD_SIZE  register file write data

Function
REQ-004 ll transfer SHALL occur on a clk edge with ll_valid and ll_ready both high; ll_ready = buffer not full, independent of ll_valid.
REQ-005 An accepted ll result with ll_addr = 0 SHALL be discarded, never buffered or written.
REQ-006 Write port priority per cycle: pipe_we=1 drives pipe_addr/pipe_data; else buffer non-empty drives head entry and pops it at the edge; else reg_d_we=0.
REQ-007 reg_d_we/addr/data SHALL be combinational from the selected source; zero added latency for the pipeline path.
REQ-008 Buffer SHALL be FIFO; push and pop in the same cycle SHALL keep occupancy unchanged; pointers wrap modulo DEPTH.
REQ-009 pend_a/pend_b SHALL be combinational, high when any valid buffer entry matches the query address and the query address is nonzero.
REQ-010 Starve counter SHALL increment each cycle the buffer is full and the head is not popped, clear on any pop, saturate at STARVE_LIMIT.
REQ-011 stall_req SHALL be registered, set when the counter reaches STARVE_LIMIT, and clear the cycle after the buffer stops being full.
REQ-012 While stall_req is high, pipe_we=1 SHALL still win the port and set proto_err (sticky until reset).
REQ-013 Simultaneous pipe_we and ll push with full buffer: no pop, no push, ll_ready stays 0, no data lost.

Reset
REQ-014 While rst_n=0: buffer empty, counter 0, stall_req 0, proto_err 0, ll_ready 0, reg_d_we 0, pend_a/pend_b 0; reset mid-operation SHALL drop buffered entries without writing them.

Configuration
REQ-015 With WB_ARB_BYPASS_EN defined: an accepted ll result SHALL be written the same cycle when pipe_we=0 and the buffer is empty, without being buffered; without it, every ll result is buffered first (minimum one-cycle latency).

Structure
REQ-016 A shared package wb_pkg SHALL hold ADDR_SIZE/WORD_SIZE defaults and the write-request record (we, addr, data).
REQ-017 The buffer SHALL be sub-module wb_pend_fifo with push/pop, full/empty, head outputs and two address-match ports.

Verification
REQ-018 Reset release, idle inputs -> reg_d_we=0, ll_ready=1, stall_req=0.
REQ-019 pipe_we=1 addr 3 data 0xA5A5A5A5 with ll_valid addr 7 data 0x1234 -> cycle 0 writes r3; next cycle writes r7 = 0x1234; pend_a high for query 7 until the r7 write completes.
REQ-020 Two ll pushes during continuous pipe_we -> ll_ready=0 at full; after STARVE_LIMIT=4 full cycles stall_req=1; pipe_we dropped -> both entries drain in order, stall_req clears.
REQ-021 pipe_we=1 while stall_req=1 -> pipe write occurs, proto_err=1 and stays high.
REQ-022 ll_valid addr 0 -> ll_ready handshake, no reg_d_we, pend_a low for query 0.
REQ-023 Bypass build, empty buffer, pipe_we=0, ll addr 9 data 0x55 -> reg_d_we=1 same cycle; non-bypass build -> write one cycle later.
